// File: rtl/wb_scratch_responder_pkg.sv
// rtl/wb_scratch_responder_pkg.sv - word indices, FSM encoding and byte-lane merge shared by the responder
package wb_scratch_responder_pkg;

  localparam logic [11:0] WBR_IDX_ID    = 12'hFFF;
  localparam logic [11:0] WBR_IDX_CNT   = 12'hFFE;
  localparam logic [11:0] WBR_IDX_STALL = 12'hFFD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wbr_state_e;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int n = 0; n < 4; n++) begin
      res[8*n +: 8] = sel[n] ? new_word[8*n +: 8] : old_word[8*n +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_scratch_responder_regfile.sv
// rtl/wb_scratch_responder_regfile.sv - DEPTH x 32 scratch words, byte-lane write, async read by word index
module wb_resp_regfile
  import wb_scratch_responder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  logic [11:0] wr_idx_i,
  input  logic [3:0]  wr_sel_i,
  input  logic [31:0] wr_data_i,
  input  logic [11:0] rd_idx_i,
  output logic [31:0] rd_data_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem_q [DEPTH];
  logic        wr_hit;
  logic        rd_hit;

  // Indices at or beyond DEPTH fall through to the top-level read mux
  assign wr_hit = (wr_idx_i < 12'(DEPTH));
  assign rd_hit = (rd_idx_i < 12'(DEPTH));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else if (wr_en_i && wr_hit) begin
      mem_q[wr_idx_i[AW-1:0]] <= lane_merge(mem_q[wr_idx_i[AW-1:0]], wr_data_i, wr_sel_i);
    end
  end

  assign rd_data_o = rd_hit ? mem_q[rd_idx_i[AW-1:0]] : 32'h0;

endmodule

// File: rtl/wb_scratch_responder.sv
// rtl/wb_scratch_responder.sv - Wishbone classic scratch/ID/counter responder with programmable wait states
// Optional WBRESP_STALL_EN adds a 4-bit run-time stall register at word index 12'hFFD.
module wb_scratch_responder
  import wb_scratch_responder_pkg::*;
#(
  parameter int          DEPTH       = 8,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'h55534244
) (
  input  logic        ctrlCd_clk,
  input  logic        ctrlCd_reset,
  input  logic        wb_CYC,
  input  logic        wb_STB,
  input  logic        wb_WE,
  input  logic [13:0] wb_ADR,
  input  logic [3:0]  wb_SEL,
  input  logic [31:0] wb_DAT_MOSI,
  output logic        wb_ACK,
  output logic [31:0] wb_DAT_MISO,
  output logic        busy
);

  wbr_state_e  state_q, state_d;
  logic        we_q;
  logic [11:0] idx_q;
  logic [3:0]  sel_q;
  logic [31:0] wdat_q;
  logic [4:0]  wcnt_q;
  logic [15:0] cnt_q;
  logic        ack_q;
  logic [31:0] miso_q;
  logic [3:0]  stall;
  logic [4:0]  total_waits;
  logic        accept;
  logic        in_ack;
  logic [11:0] rd_idx;
  logic        rd_we;
  logic [31:0] rf_rdata;
  logic [31:0] rd_data;
  logic        unused_adr;

  assign unused_adr  = ^wb_ADR[1:0];
  assign total_waits = 5'(WAIT_STATES) + {1'b0, stall};

  always_ff @(posedge ctrlCd_clk) begin
    if (ctrlCd_reset) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (wb_CYC && wb_STB) state_d = (total_waits == 5'd0) ? ACK : WAIT;
      WAIT: begin
        if (!wb_CYC)               state_d = IDLE;
        else if (wcnt_q <= 5'd1)   state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept = (state_q == IDLE) && wb_CYC && wb_STB;
    in_ack = (state_q == ACK);
    busy   = (state_q == WAIT) || (state_q == ACK);
  end

  // Read data is registered on entry to ACK, so in IDLE it must come straight off the bus
  assign rd_idx = (state_q == IDLE) ? wb_ADR[13:2] : idx_q;
  assign rd_we  = (state_q == IDLE) ? wb_WE : we_q;

  always_ff @(posedge ctrlCd_clk) begin
    if (ctrlCd_reset) begin
      we_q   <= 1'b0;
      idx_q  <= '0;
      sel_q  <= '0;
      wdat_q <= '0;
      wcnt_q <= '0;
    end else if (accept) begin
      we_q   <= wb_WE;
      idx_q  <= wb_ADR[13:2];
      sel_q  <= wb_SEL;
      wdat_q <= wb_DAT_MOSI;
      wcnt_q <= total_waits;
    end else if (state_q == WAIT) begin
      wcnt_q <= wcnt_q - 5'd1;
    end
  end

  // Clear wins over the increment when the counter itself is written
  always_ff @(posedge ctrlCd_clk) begin
    if (ctrlCd_reset) begin
      cnt_q <= '0;
    end else if (in_ack) begin
      if (we_q && (idx_q == WBR_IDX_CNT) && (sel_q != 4'h0)) cnt_q <= '0;
      else                                                   cnt_q <= cnt_q + 16'd1;
    end
  end

`ifdef WBRESP_STALL_EN
  logic [3:0] stall_q;

  always_ff @(posedge ctrlCd_clk) begin
    if (ctrlCd_reset) begin
      stall_q <= '0;
    end else if (in_ack && we_q && (idx_q == WBR_IDX_STALL) && sel_q[0]) begin
      stall_q <= wdat_q[3:0];
    end
  end

  assign stall = stall_q;
`else
  assign stall = 4'd0;
`endif

  wb_resp_regfile #(
    .DEPTH(DEPTH)
  ) u_regfile (
    .clk_i     (ctrlCd_clk),
    .rst_i     (ctrlCd_reset),
    .wr_en_i   (in_ack && we_q),
    .wr_idx_i  (idx_q),
    .wr_sel_i  (sel_q),
    .wr_data_i (wdat_q),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rf_rdata)
  );

  // The counter read reports the value after its own increment
  always_comb begin
    rd_data = rf_rdata;
    case (rd_idx)
      WBR_IDX_ID:    rd_data = ID_VALUE;
      WBR_IDX_CNT:   rd_data = {16'h0, cnt_q + 16'd1};
`ifdef WBRESP_STALL_EN
      WBR_IDX_STALL: rd_data = {28'h0, stall};
`endif
      default:       rd_data = rf_rdata;
    endcase
  end

  always_ff @(posedge ctrlCd_clk) begin
    if (ctrlCd_reset) begin
      ack_q  <= 1'b0;
      miso_q <= '0;
    end else begin
      ack_q  <= (state_d == ACK);
      miso_q <= ((state_d == ACK) && !rd_we) ? rd_data : 32'h0;
    end
  end

  assign wb_ACK      = ack_q;
  assign wb_DAT_MISO = miso_q;

endmodule

// File: tb/tb_wb_scratch_responder.sv
// tb/tb_wb_scratch_responder.sv - scoreboard bench for wb_scratch_responder at 0 and 3 wait states
module tb_wb_scratch_responder;
  import wb_scratch_responder_pkg::*;

  typedef struct {
    logic [31:0] data;
    bit          chk;
    int          lat;
    int          issue;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc  [2];
  logic        stb  [2];
  logic        we   [2];
  logic [13:0] adr  [2];
  logic [3:0]  sel  [2];
  logic [31:0] mosi [2];
  logic        ack  [2];
  logic [31:0] miso [2];
  logic        busy [2];

  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;
  int   bcnt1  = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  always @(negedge clk) bcnt1 += int'(busy[1]);

  wb_scratch_responder #(.DEPTH(8), .WAIT_STATES(0), .ID_VALUE(32'h55534244)) u_d0 (
    .ctrlCd_clk(clk), .ctrlCd_reset(rst),
    .wb_CYC(cyc[0]), .wb_STB(stb[0]), .wb_WE(we[0]), .wb_ADR(adr[0]),
    .wb_SEL(sel[0]), .wb_DAT_MOSI(mosi[0]),
    .wb_ACK(ack[0]), .wb_DAT_MISO(miso[0]), .busy(busy[0])
  );

  wb_scratch_responder #(.DEPTH(8), .WAIT_STATES(3), .ID_VALUE(32'h55534244)) u_d3 (
    .ctrlCd_clk(clk), .ctrlCd_reset(rst),
    .wb_CYC(cyc[1]), .wb_STB(stb[1]), .wb_WE(we[1]), .wb_ADR(adr[1]),
    .wb_SEL(sel[1]), .wb_DAT_MOSI(mosi[1]),
    .wb_ACK(ack[1]), .wb_DAT_MISO(miso[1]), .busy(busy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic score(input int i, input exp_t e);
    check({e.name, " latency"}, 32'(cyc_n - e.issue), 32'(e.lat));
    if (e.chk) check({e.name, " data"}, miso[i], e.data);
  endtask

  always @(negedge clk) begin
    if (ack[0] === 1'b1) begin
      if (q0.size() == 0) check("d0 unexpected ack", 32'(ack[0]), 32'h0);
      else                score(0, q0.pop_front());
    end
    if (ack[1] === 1'b1) begin
      if (q1.size() == 0) check("d3 unexpected ack", 32'(ack[1]), 32'h0);
      else                score(1, q1.pop_front());
    end
  end

  task automatic access(input int i, input bit wr, input logic [11:0] idx, input logic [3:0] s,
                        input logic [31:0] d, input logic [31:0] exp, input int lat, input string name);
    exp_t e;
    int   n;
    @(negedge clk);
    cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = wr; adr[i] = {idx, 2'b00}; sel[i] = s; mosi[i] = d;
    e.data = exp; e.chk = !wr; e.lat = lat; e.issue = cyc_n; e.name = name;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((ack[i] !== 1'b1) && (n < 40));
    if (ack[i] !== 1'b1) begin
      check({name, " ack timeout"}, 32'h0, 32'h1);
      if (i == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
    stb[i] = 1'b0; we[i] = 1'b0;
    @(negedge clk);
    cyc[i] = 1'b0;
  endtask

  task automatic abort_write(input int i, input logic [11:0] idx, input logic [31:0] d);
    @(negedge clk);
    cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = 1'b1; adr[i] = {idx, 2'b00}; sel[i] = 4'hF; mosi[i] = d;
    repeat (2) @(negedge clk);
    cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 0; stb[i] = 0; we[i] = 0; adr[i] = '0; sel[i] = '0; mosi[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("reset ack", 32'(ack[i]), 32'h0);
      check("reset miso", miso[i], 32'h0);
      check("reset busy", 32'(busy[i]), 32'h0);
    end

    access(0, 0, 12'hFFF, 4'hF, 32'h0, 32'h55534244, 1, "id read");
    access(0, 1, 12'd3, 4'b0101, 32'hA1B2C3D4, 32'h0, 1, "idx3 write lanes 0,2");
    access(0, 0, 12'd3, 4'hF, 32'h0, 32'h00B200D4, 1, "idx3 read after 0101");
    access(0, 1, 12'd3, 4'b1010, 32'h11223344, 32'h0, 1, "idx3 write lanes 1,3");
    access(0, 0, 12'd3, 4'hF, 32'h0, 32'h11B233D4, 1, "idx3 read after 1010");
    access(0, 1, 12'd7, 4'hF, 32'hDEADBEEF, 32'h0, 1, "idx7 write");
    access(0, 0, 12'd7, 4'hF, 32'h0, 32'hDEADBEEF, 1, "idx7 read");
    access(0, 1, 12'd8, 4'hF, 32'h12345678, 32'h0, 1, "idx8 write");
    access(0, 0, 12'd8, 4'hF, 32'h0, 32'h0, 1, "idx8 read");
    access(0, 1, 12'd4, 4'h0, 32'hFFFFFFFF, 32'h0, 1, "idx4 sel0 write");
    access(0, 0, 12'd4, 4'hF, 32'h0, 32'h0, 1, "idx4 read");
    access(0, 1, 12'hFFF, 4'hF, 32'h0, 32'h0, 1, "id write");
    access(0, 0, 12'hFFF, 4'hF, 32'h0, 32'h55534244, 1, "id reread");
    access(0, 0, 12'h100, 4'hF, 32'h0, 32'h0, 1, "unmapped read");
`ifdef WBRESP_STALL_EN
    access(0, 1, 12'hFFD, 4'h1, 32'h00000002, 32'h0, 1, "stall write 2");
    access(0, 0, 12'hFFD, 4'hF, 32'h0, 32'h00000002, 3, "stall read");
    access(0, 1, 12'hFFD, 4'h1, 32'h00000000, 32'h0, 3, "stall write 0");
    access(0, 0, 12'd0, 4'hF, 32'h0, 32'h0, 1, "idx0 after stall 0");
`else
    access(0, 0, 12'hFFD, 4'hF, 32'h0, 32'h0, 1, "stall idx unmapped");
`endif

    access(0, 1, 12'hFFE, 4'hF, 32'h0, 32'h0, 1, "cnt clear");
    access(0, 0, 12'hFFE, 4'hF, 32'h0, 32'h1, 1, "cnt after clear");
    access(0, 1, 12'hFFE, 4'h1, 32'h0, 32'h0, 1, "cnt clear again");
    for (int k = 0; k < 5; k++) access(0, 0, 12'd0, 4'hF, 32'h0, 32'h0, 1, "filler read");
    access(0, 0, 12'hFFE, 4'hF, 32'h0, 32'h6, 1, "cnt after 5");
    @(negedge clk);
    force u_d0.cnt_q = 16'hFFFF;
    #1 release u_d0.cnt_q;
    access(0, 0, 12'hFFE, 4'hF, 32'h0, 32'h0, 1, "cnt wrap");
    access(0, 0, 12'hFFE, 4'hF, 32'h0, 32'h1, 1, "cnt after wrap");
    access(0, 1, 12'hFFE, 4'h0, 32'h0, 32'h0, 1, "cnt sel0 write");
    access(0, 0, 12'hFFE, 4'hF, 32'h0, 32'h3, 1, "cnt after sel0 write");

    bcnt1 = 0;
    access(1, 0, 12'd0, 4'hF, 32'h0, 32'h0, 4, "ws3 idx0 read");
    check("ws3 busy cycles", 32'(bcnt1), 32'd4);
    access(1, 0, 12'hFFE, 4'hF, 32'h0, 32'h2, 4, "ws3 cnt before abort");
    abort_write(1, 12'd1, 32'hCAFEF00D);
    access(1, 0, 12'd1, 4'hF, 32'h0, 32'h0, 4, "ws3 idx1 after abort");
    access(1, 0, 12'hFFE, 4'hF, 32'h0, 32'h4, 4, "ws3 cnt after abort");

    repeat (5) @(negedge clk);
    check("scoreboard drained", 32'(q0.size() + q1.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
